// File: rtl/nios_hps_system_seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs {g,f,e,d,c,b,a}, segment a in bit 0.
package nios_hps_system_seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/nios_hps_system_seg7_glyph_rom.sv
// Combinational hex nibble to active-low seven-segment glyph (lowercase b and d).
module nios_hps_system_seg7_glyph_rom
    import nios_hps_system_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/nios_hps_system_seg7_hex_driver.sv
// Six-digit HEX display driver: frame-synchronous capture, leading-zero blanking, PWM dimming, blink.
module nios_hps_system_seg7_hex_driver
    import nios_hps_system_seg7_pkg::*;
#(
    parameter int PRESCALE     = 64,
    parameter int BLINK_FRAMES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_port,
    input  logic        blank_lz,
    input  logic [3:0]  brightness,
    input  logic        blink_en,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        frame_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PS_W-1:0] presc;
    logic [3:0]      pwm_cnt;
    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;
    logic            step_tick;
    logic            frame_end;

    logic [23:0]     value_q;
    logic            blank_q;
    logic [3:0]      bright_q;

    logic [6:0]      glyph   [NUM_DIGITS];
    logic [6:0]      hex_q   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blanked;
    logic            lit;

    assign step_tick = (presc == PS_W'(PRESCALE - 1));
    // Last cycle of the frame: capture here so the new value is live when frame_start is seen.
    assign frame_end = step_tick && (pwm_cnt == 4'hF);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= step_tick ? '0 : presc + PS_W'(1);
            pwm_cnt     <= step_tick ? pwm_cnt + 4'd1 : pwm_cnt;
            frame_start <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= '0;
            blank_q  <= 1'b0;
            bright_q <= '0;
        end else if (frame_end) begin
            value_q  <= in_port;
            blank_q  <= blank_lz;
            bright_q <= brightness;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end
    end

    // Disabling blink must relight the display immediately, not at the next frame.
    assign lit = (pwm_cnt <= bright_q) && (blink_phase || !blink_en);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        nios_hps_system_seg7_glyph_rom u_rom (
            .nibble (value_q[4*k +: 4]),
            .glyph  (glyph[k])
        );
        if (k == 0) begin : g_units
            assign blanked[k] = 1'b0;
        end else begin : g_upper
            assign blanked[k] = blank_q && (value_q[23:4*k] == '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (reset)
                hex_q[k] <= SEG_OFF;
            else
                hex_q[k] <= (lit && !blanked[k]) ? glyph[k] : SEG_OFF;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_nios_hps_system_seg7_hex_driver.sv
// Scoreboard bench for the HEX driver: cycle-level reference model plus directed scenario checks.
module tb_nios_hps_system_seg7_hex_driver;

    localparam int P  = 2;
    localparam int BF = 4;
    localparam int FR = 16 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] in_port = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic        blink_en = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        frame_start;

    always #5 clk = ~clk;

    nios_hps_system_seg7_hex_driver #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_port     (in_port),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .blink_en    (blink_en),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .frame_start (frame_start)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0]  gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [42:0] exp_q [$];

    // Reference model: time within the frame plus the settings latched at each frame boundary.
    int          m_t = 0;
    logic [23:0] m_val = '0;
    logic        m_blank = 1'b0;
    logic [3:0]  m_bri = '0;
    logic        m_phase = 1'b1;
    int          m_bcnt = 0;

    task automatic tick();
        logic [42:0] e;
        int          pwm;
        logic        on;
        logic        blanked;
        e = {{6{7'h7F}}, 1'b0};
        if (!reset) begin
            pwm = (m_t % FR) / P;
            on  = (pwm <= int'(m_bri)) && (m_phase || !blink_en);
            for (int k = 0; k < 6; k++) begin
                blanked = (k > 0) && m_blank && ((m_val >> (4 * k)) == 24'd0);
                e[7*k+1 +: 7] = (on && !blanked) ? gly[m_val[4*k +: 4]] : 7'h7F;
            end
            e[0] = ((m_t % FR) == FR - 1);
        end
        exp_q.push_back(e);
        if (reset) begin
            m_t = 0; m_val = '0; m_blank = 1'b0; m_bri = '0; m_phase = 1'b1; m_bcnt = 0;
        end else begin
            if ((m_t % FR) == FR - 1) begin
                m_val = in_port; m_blank = blank_lz; m_bri = brightness;
                if (blink_en) begin
                    m_bcnt++;
                    if (m_bcnt == BF) begin
                        m_bcnt  = 0;
                        m_phase = !m_phase;
                    end
                end
            end
            if (!blink_en) begin
                m_bcnt  = 0;
                m_phase = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [42:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({hex5, hex4, hex3, hex2, hex1, hex0, frame_start} !== e) begin
                    bad++;
                    $display("FAIL scoreboard at %0t: got %h want %h", $time,
                             {hex5, hex4, hex3, hex2, hex1, hex0, frame_start}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 400);
        if (!frame_start) begin
            total++;
            bad++;
            $display("FAIL frame_start_timeout: got 0 want 1 within 400 cycles");
        end
    endtask

    initial begin : stim
        int n;
        int on_cnt;
        in_port = 24'h123456;
        tick();
        tick();
        chk("reset_hex0", int'(hex0), 'h7F);
        chk("reset_fs", int'(frame_start), 0);
        reset = 1'b0;
        wait_fs(n);
        chk("first_fs_latency", n, 32);
        tick();
        chk("first_hex0", int'(hex0), 'h02);
        chk("first_hex5", int'(hex5), 'h79);

        in_port = 24'h000008;
        brightness = 4'd0;
        wait_fs(n);
        wait_fs(n);
        on_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (hex0 == 7'h00) on_cnt++;
        end
        chk("bright0_on_cycles", on_cnt, 2);
        brightness = 4'hF;
        wait_fs(n);
        on_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (hex0 == 7'h00) on_cnt++;
        end
        chk("bright15_on_cycles", on_cnt, 32);

        blank_lz = 1'b1;
        in_port = 24'h000A00;
        wait_fs(n);
        tick();
        chk("blank_hex5", int'(hex5), 'h7F);
        chk("blank_hex3", int'(hex3), 'h7F);
        chk("blank_hex2", int'(hex2), 'h08);
        chk("blank_hex1", int'(hex1), 'h40);
        chk("blank_hex0", int'(hex0), 'h40);
        in_port = 24'h0;
        wait_fs(n);
        tick();
        chk("zero_hex0", int'(hex0), 'h40);
        chk("zero_hex1", int'(hex1), 'h7F);

        blank_lz = 1'b0;
        in_port = 24'h111111;
        wait_fs(n);
        for (int i = 0; i < 14; i++) tick();
        in_port = 24'h222222;
        wait_fs(n);
        chk("tear_old_hex0", int'(hex0), 'h79);
        tick();
        chk("tear_new_hex0", int'(hex0), 'h24);

        blink_en = 1'b1;
        n = 0;
        while (hex0 != 7'h7F && n < 400) begin
            tick();
            n++;
        end
        chk("blink_goes_dark", int'(hex0), 'h7F);
        blink_en = 1'b0;
        tick();
        chk("blink_off_relit", int'(hex0), 'h24);

        wait_fs(n);
        for (int i = 0; i < 18; i++) tick();
        reset = 1'b1;
        tick();
        chk("midframe_reset_hex0", int'(hex0), 'h7F);
        reset = 1'b0;
        wait_fs(n);
        chk("post_reset_fs_latency", n, 32);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) in_port = $urandom();
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom());
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom());
            if ($urandom_range(0, 63) == 0) blink_en = 1'($urandom());
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
